// File: rtl/data_type_pkg.sv
// Shared types for the bfloat16 FPU issuer: opcodes, FSM states and the packed
// response record that travels through the response FIFO.
package data_type_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  tag;
        logic        div_zero;
        logic        overflow;
        logic        illegal;
    } rsp_t;

    localparam int RSP_W = $bits(rsp_t);

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic rsp_is_err(input rsp_t r);
        return r.div_zero | r.overflow | r.illegal;
    endfunction

endpackage

// File: rtl/fpu_issuer_fifo.sv
// Synchronous response FIFO with occupancy count; the head reads as zero when
// empty so downstream fields are quiet whenever nothing is presented.
module fpu_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 23
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A push into a full FIFO is only allowed when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/fpu_issuer.sv
// Issues one bfloat16 request at a time to an external combinational FPU and
// queues the tagged result (or an illegal-opcode marker) in a response FIFO.
//
// state | meaning
// IDLE  | ready for a request when the response FIFO has room
// EXEC  | operands on the FPU inputs; result and flags captured this cycle
// DONE  | response pushed into the FIFO
module fpu_issuer
    import data_type_pkg::*;
#(
    parameter int RSP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [3:0]  req_op_i,
    input  logic [15:0] req_a_i,
    input  logic [15:0] req_b_i,
    input  logic [3:0]  req_tag_i,
    output logic [3:0]  fpu_op_o,
    output logic [15:0] fpu_in1_o,
    output logic [15:0] fpu_in2_o,
    input  logic [15:0] fpu_out_i,
    input  logic        fpu_div_zero_err_i,
    input  logic        fpu_overflow_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [15:0] rsp_data_o,
    output logic [3:0]  rsp_tag_o,
    output logic        rsp_div_zero_o,
    output logic        rsp_overflow_o,
    output logic        rsp_illegal_o,
    output logic        busy_o,
    output logic [7:0]  err_cnt_o
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;

    state_e         state_q, state_d;
    logic [3:0]     op_q;
    logic [15:0]    a_q, b_q;
    logic [3:0]     tag_q;
    logic [15:0]    data_q;
    logic           dz_q, ovf_q, ill_q;
    logic [7:0]     err_cnt_q;

    logic [CW-1:0]    fifo_count;
    logic [RSP_W-1:0] fifo_head_raw;
    logic             fifo_valid;
    logic             fifo_room;
    logic             accept;
    logic             push;
    rsp_t             push_rsp;
    rsp_t             head;

    assign fifo_room = (fifo_count < CW'(RSP_DEPTH));

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        accept      = 1'b0;
        push        = 1'b0;
        fpu_op_o    = '0;
        fpu_in1_o   = '0;
        fpu_in2_o   = '0;
        case (state_q)
            IDLE: begin
                req_ready_o = fifo_room;
                accept      = req_valid_i && fifo_room;
                if (accept) begin
                    state_d = is_legal_op(req_op_i) ? EXEC : DONE;
                end
            end
            EXEC: begin
                fpu_op_o  = op_q;
                fpu_in1_o = a_q;
                fpu_in2_o = b_q;
                state_d   = DONE;
            end
            DONE: begin
                push    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Illegal opcodes skip EXEC, so their result fields are settled at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            tag_q  <= '0;
            data_q <= '0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= req_op_i;
                a_q    <= req_a_i;
                b_q    <= req_b_i;
                tag_q  <= req_tag_i;
                data_q <= '0;
                dz_q   <= 1'b0;
                ovf_q  <= 1'b0;
                ill_q  <= !is_legal_op(req_op_i);
            end
            if (state_q == EXEC) begin
                data_q <= fpu_out_i;
                dz_q   <= fpu_div_zero_err_i;
                ovf_q  <= fpu_overflow_i;
            end
        end
    end

    assign push_rsp = '{data: data_q, tag: tag_q, div_zero: dz_q, overflow: ovf_q, illegal: ill_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (push && rsp_is_err(push_rsp) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    fpu_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (RSP_W)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (push_rsp),
        .pop_i   (rsp_valid_o && rsp_ready_i),
        .data_o  (fifo_head_raw),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign head           = rsp_t'(fifo_head_raw);
    assign rsp_valid_o    = fifo_valid;
    assign rsp_data_o     = head.data;
    assign rsp_tag_o      = head.tag;
    assign rsp_div_zero_o = head.div_zero;
    assign rsp_overflow_o = head.overflow;
    assign rsp_illegal_o  = head.illegal;
    assign busy_o         = (state_q != IDLE);
    assign err_cnt_o      = err_cnt_q;

endmodule

// File: tb/tb_fpu_issuer.sv
// Bench for fpu_issuer: a behavioural bfloat16 FPU is attached, a queue-based
// reference predicts every response, and a negedge monitor compares the DUT.
module tb_fpu_issuer;
    import data_type_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [3:0]  req_op_i = '0;
    logic [15:0] req_a_i = '0;
    logic [15:0] req_b_i = '0;
    logic [3:0]  req_tag_i = '0;
    logic [3:0]  fpu_op_o;
    logic [15:0] fpu_in1_o, fpu_in2_o;
    logic [15:0] fpu_out;
    logic        fpu_dz, fpu_ovf;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [15:0] rsp_data_o;
    logic [3:0]  rsp_tag_o;
    logic        rsp_div_zero_o, rsp_overflow_o, rsp_illegal_o;
    logic        busy_o;
    logic [7:0]  err_cnt_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    fpu_issuer #(.RSP_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_op_i           (req_op_i),
        .req_a_i            (req_a_i),
        .req_b_i            (req_b_i),
        .req_tag_i          (req_tag_i),
        .fpu_op_o           (fpu_op_o),
        .fpu_in1_o          (fpu_in1_o),
        .fpu_in2_o          (fpu_in2_o),
        .fpu_out_i          (fpu_out),
        .fpu_div_zero_err_i (fpu_dz),
        .fpu_overflow_i     (fpu_ovf),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_ready_i        (rsp_ready_i),
        .rsp_data_o         (rsp_data_o),
        .rsp_tag_o          (rsp_tag_o),
        .rsp_div_zero_o     (rsp_div_zero_o),
        .rsp_overflow_o     (rsp_overflow_o),
        .rsp_illegal_o      (rsp_illegal_o),
        .busy_o             (busy_o),
        .err_cnt_o          (err_cnt_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural bfloat16 FPU (denormals flush to zero, truncating) ----------------
    function automatic real bf2r(input logic [15:0] v);
        real m;
        if (v[14:7] == 8'h00) return 0.0;
        m = (1.0 + real'(v[6:0]) / 128.0) * (2.0 ** real'(int'(v[14:7]) - 127));
        return v[15] ? -m : m;
    endfunction

    function automatic logic [16:0] r2bf(input real r);
        real  x;
        int   e;
        int   m;
        logic s;
        if (r == 0.0) return 17'h0;
        s = (r < 0.0);
        x = s ? -r : r;
        e = 127;
        while (x >= 2.0) begin x = x / 2.0; e++; end
        while (x < 1.0)  begin x = x * 2.0; e--; end
        if (e >= 255) return {1'b1, s, 15'h7F80};
        if (e <= 0)   return {1'b0, s, 15'h0000};
        m = $rtoi((x - 1.0) * 128.0);
        return {1'b0, s, e[7:0], m[6:0]};
    endfunction

    // returns {div_zero, overflow, data}
    function automatic logic [17:0] fpu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        real ra, rb, r;
        ra = bf2r(a);
        rb = bf2r(b);
        case (op)
            4'd0: r = ra + rb;
            4'd1: r = ra - rb;
            4'd2: r = ra * rb;
            4'd3: begin
                if (b[14:7] == 8'h00) return {1'b1, 1'b0, a[15] ^ b[15], 15'h7F80};
                r = ra / rb;
            end
            default: return 18'h0;
        endcase
        return {1'b0, r2bf(r)};
    endfunction

    always_comb {fpu_dz, fpu_ovf, fpu_out} = fpu_fn(fpu_op_o, fpu_in1_o, fpu_in2_o);

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [15:0] data;
        logic [3:0]  tag;
        logic        dz;
        logic        ovf;
        logic        ill;
        int          vis;   // first monitor cycle at which this entry is in the FIFO
    } exp_t;

    exp_t sbq[$];

    initial begin
        int          c, occ, lat, busy_lo, busy_hi, exec_at, err_model, pend_vis, err_exp;
        logic        exp_valid, busy_exp, exp_ready;
        logic [35:0] fpu_exp, fpu_req;
        exp_t        e;
        busy_lo = -1; busy_hi = -2; exec_at = -1; err_model = 0; pend_vis = -1; fpu_req = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_rsp", {rsp_valid_o, busy_o, err_cnt_o, rsp_data_o, rsp_tag_o,
                                  rsp_div_zero_o, rsp_overflow_o, rsp_illegal_o}, 64'h0);
                chk("reset_fpu", {fpu_op_o, fpu_in1_o, fpu_in2_o}, 64'h0);
                sbq.delete();
                busy_lo = -1; busy_hi = -2; exec_at = -1; err_model = 0; pend_vis = -1;
            end else begin
                c = cyc;
                occ = 0;
                foreach (sbq[i]) if (sbq[i].vis <= c) occ++;
                exp_valid = (occ > 0);
                busy_exp  = (c >= busy_lo) && (c <= busy_hi);
                exp_ready = !busy_exp && (occ < DEPTH);
                fpu_exp   = (c == exec_at) ? fpu_req : 36'h0;
                err_exp   = err_model - ((pend_vis > c) ? 1 : 0);
                if (err_exp > 255) err_exp = 255;

                chk("rsp_valid", rsp_valid_o, exp_valid);
                chk("req_ready", req_ready_o, exp_ready);
                chk("busy", busy_o, busy_exp);
                chk("fpu_drive", {fpu_op_o, fpu_in1_o, fpu_in2_o}, fpu_exp);
                chk("err_cnt", err_cnt_o, err_exp[7:0]);

                if (exp_valid) begin
                    chk("rsp_head", {rsp_data_o, rsp_tag_o, rsp_div_zero_o, rsp_overflow_o, rsp_illegal_o},
                        {sbq[0].data, sbq[0].tag, sbq[0].dz, sbq[0].ovf, sbq[0].ill});
                    if (rsp_ready_i) void'(sbq.pop_front());
                end

                if (req_valid_i && exp_ready) begin
                    if (req_op_i > 4'd3) begin
                        e.data = 16'h0; e.dz = 1'b0; e.ovf = 1'b0; e.ill = 1'b1;
                        lat = 2;
                        exec_at = -1;
                    end else begin
                        {e.dz, e.ovf, e.data} = fpu_fn(req_op_i, req_a_i, req_b_i);
                        e.ill = 1'b0;
                        lat = 3;
                        exec_at = c + 1;
                        fpu_req = {req_op_i, req_a_i, req_b_i};
                    end
                    e.tag = req_tag_i;
                    e.vis = c + lat;
                    sbq.push_back(e);
                    busy_lo = c + 1;
                    busy_hi = c + lat - 1;
                    if (e.dz || e.ovf || e.ill) begin
                        err_model++;
                        pend_vis = e.vis;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_accept();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready_o) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag);
        req_op_i    = op;
        req_a_i     = a;
        req_b_i     = b;
        req_tag_i   = tag;
        req_valid_i = 1'b1;
        wait_accept();
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (rsp_valid_o) break;
            n++;
            if (n > 50) begin
                chk("rsp_timeout", 64'd1, 64'd0);
                break;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy_o && !rsp_valid_o) break;
            n++;
            if (n > 300) begin
                chk("drain_timeout", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_bf();
        int   r;
        logic [7:0] ex;
        r = $urandom_range(0, 9);
        if (r == 0)      ex = 8'h00;
        else if (r < 3)  ex = 8'($urandom_range(200, 254));
        else             ex = 8'($urandom_range(100, 154));
        return {1'($urandom_range(0, 1)), ex, 7'($urandom_range(0, 127))};
    endfunction

    logic rand_done = 1'b0;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(OP_ADD, 16'h3F80, 16'h3F80, 4'd3);
        wait_rsp();
        chk("add_one_one", {rsp_data_o, rsp_tag_o, rsp_div_zero_o, rsp_overflow_o, rsp_illegal_o},
            {16'h4000, 4'd3, 3'b000});
        drain();

        send(OP_DIV, 16'h3F80, 16'h0000, 4'd5);
        wait_rsp();
        chk("div_zero_flag", rsp_div_zero_o, 1'b1);
        drain();
        chk("err_cnt_div", err_cnt_o, 8'd1);

        send(4'hF, 16'h1234, 16'h5678, 4'd7);
        wait_rsp();
        chk("illegal_rsp", {rsp_data_o, rsp_tag_o, rsp_illegal_o}, {16'h0000, 4'd7, 1'b1});
        drain();
        chk("err_cnt_ill", err_cnt_o, 8'd2);

        // back-pressure: four fit, the fifth waits for a pop
        rsp_ready_i = 1'b0;
        for (int t = 0; t < 4; t++) send(4'($urandom_range(0, 3)), rand_bf(), rand_bf(), 4'(t));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_ready_low", req_ready_o, 1'b0);
        @(posedge clk);
        #1;
        req_op_i = OP_MUL; req_a_i = 16'h4040; req_b_i = 16'h4000; req_tag_i = 4'd4;
        req_valid_i = 1'b1;
        repeat (5) @(posedge clk);
        #1 rsp_ready_i = 1'b1;
        wait_accept();
        drain();

        // asynchronous reset while the request is in EXEC
        send(OP_SUB, 16'h4000, 16'h3F80, 4'd9);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_rsp", {rsp_valid_o, busy_o, err_cnt_o, rsp_data_o, rsp_tag_o,
                              rsp_div_zero_o, rsp_overflow_o, rsp_illegal_o}, 64'h0);
        chk("async_rst_fpu", {fpu_op_o, fpu_in1_o, fpu_in2_o}, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", req_ready_o, 1'b1);
        chk("no_rsp_after_rst", rsp_valid_o, 1'b0);
        @(posedge clk);
        #1;

        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    logic [3:0] op;
                    int gap;
                    gap = $urandom_range(0, 3);
                    repeat (gap) begin @(posedge clk); #1; end
                    op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
                    send(op, rand_bf(), rand_bf(), 4'($urandom_range(0, 15)));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 rsp_ready_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready_i = 1'b1;
        drain();

        for (int i = 0; i < 300; i++) send(4'($urandom_range(4, 15)), rand_bf(), rand_bf(), 4'(i));
        drain();
        chk("err_cnt_sat", err_cnt_o, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_issuer.md
FPU_ISSUER -- requirements
Module: fpu_issuer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have req_valid_i  in  1  request present.
REQ-003 SHALL have req_ready_o  out  1  request accepted when high with req_valid_i.
REQ-004 SHALL have req_op_i  in  4  opcode; req_a_i  in  16  bfloat16 operand 1; req_b_i  in  16  bfloat16 operand 2; req_tag_i  in  4  caller tag.
REQ-005 SHALL have fpu_op_o  out  4; fpu_in1_o  out  16; fpu_in2_o  out  16. These drive the combinational FPU inputs.
REQ-006 SHALL have fpu_out_i  in  16; fpu_div_zero_err_i  in  1; fpu_overflow_i  in  1. These are the FPU results.
REQ-007 SHALL have rsp_valid_o  out  1; rsp_ready_i  in  1; rsp_data_o  out  16; rsp_tag_o  out  4; rsp_div_zero_o  out  1; rsp_overflow_o  out  1; rsp_illegal_o  out  1.
REQ-008 SHALL have busy_o  out  1  FSM not IDLE; err_cnt_o  out  8  saturating error-response count.
REQ-009 SHALL use parameter RSP_DEPTH, default 4, meaning response FIFO entries (power of two, min 2).

Function
REQ-010 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-011 SHALL drive req_ready_o = (state==IDLE) && (fifo count < RSP_DEPTH), combinationally.
REQ-012 SHALL, on accept in IDLE, register op/a/b/tag and go to EXEC for legal opcodes (ADD=0, SUB=1, MUL=2, DIV=3) and to DONE for any other opcode.
REQ-013 SHALL, in EXEC, drive fpu_op_o/fpu_in1_o/fpu_in2_o from the operand registers and capture fpu_out_i and both flags at the end of the cycle, then go to DONE.
REQ-014 SHALL drive fpu_op_o, fpu_in1_o and fpu_in2_o to zero in every state except EXEC.
REQ-015 SHALL, in DONE, push {data, tag, div_zero, overflow, illegal} into the response FIFO, then return to IDLE unconditionally.
REQ-016 SHALL, for an illegal opcode, push data 16'h0000 with illegal=1 and div_zero=overflow=0, and SHALL NOT drive the FPU.
REQ-017 SHALL have a latency from accept edge N to rsp_valid_o high at cycle N+3 for a legal op with an empty FIFO, and N+2 for an illegal op.
REQ-018 SHALL allow a maximum accept rate of one request every 3 cycles (legal) or every 2 cycles (illegal).
REQ-019 SHALL assert rsp_valid_o whenever the FIFO is non-empty; the head fields SHALL stay stable while rsp_valid_o is high and rsp_ready_i is low.
REQ-020 SHALL pop on rsp_valid_o && rsp_ready_i; a simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-021 SHALL never overflow the FIFO, because accept requires a free slot and only one request is in flight.
REQ-022 SHALL increment err_cnt_o at each push with div_zero|overflow|illegal set, saturating at 8'hFF.
REQ-023 SHALL return responses strictly in acceptance order.

Reset
REQ-024 SHALL, while rst_n is low, force state IDLE, FIFO empty, rsp_valid_o=0, err_cnt_o=0, busy_o=0, all rsp_* data/flags=0 and fpu_* outputs=0.
REQ-025 SHALL, on reset mid-operation (EXEC/DONE), discard the in-flight request with no response produced; after release, req_ready_o SHALL be 1 on the first cycle.

Structure
REQ-026 SHALL define opcode constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV), the FSM state enum and a packed response struct in the shared data_type_pkg.
REQ-027 SHALL contain one sub-module, fpu_rsp_fifo (synchronous FIFO, parameterised depth and width, count output).
REQ-028 SHALL NOT contain the FPU itself; the FPU is instantiated alongside fpu_issuer by the integrating level.

Verification
REQ-029 SHALL cover: ADD 0x3F80 + 0x3F80, tag 3, with a real FPU attached -> rsp_data 0x4000, tag 3, flags 0, rsp_valid_o at accept+3.
REQ-030 SHALL cover: DIV 0x3F80 / 0x0000 -> rsp_div_zero_o=1 and err_cnt_o=1.
REQ-031 SHALL cover: opcode 4'hF -> rsp_illegal_o=1, data 0x0000, fpu_op_o/in1/in2 zero throughout, response at accept+2.
REQ-032 SHALL cover: rsp_ready_i=0 with 5 back-to-back requests (tags 0-4) -> 4 accepted, req_ready_o low after the 4th DONE; then rsp_ready_i=1 -> tags 0,1,2,3 in order, then tag 4 accepted.
REQ-033 SHALL cover: rst_n asserted during EXEC -> no response, all outputs 0 immediately (asynchronous), req_ready_o=1 after release.
REQ-034 SHALL cover: 300 illegal-op requests -> err_cnt_o saturates at 8'hFF.
